instruction_feeder: RTL and testbench

- Supplies 11-bit instructions to the accumulator core. Each instruction is opcode[10:8] plus literal[7:0].
- Runs a small program loaded into internal storage, one instruction per core fetch cycle. The core's fetch strobe f is the handshake.
- Samples the core's accumulator and flags after each executed instruction and reports them to the testbench or board LEDs.
- Sits between the switch/loader logic and the core's `in` port.

---
 rtl/feeder_pkg.sv | 31 +++
 rtl/feeder_prog_mem.sv | 28 ++
 rtl/instruction_feeder.sv | 196 +++++++++++++++++++
 tb/tb_instruction_feeder.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/feeder_pkg.sv
// Shared types and constants for the instruction feeder: FSM states, the
// core's opcode map, the NOP encoding and the bit positions of the core flags.
package feeder_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } feeder_state_e;

   localparam int INSTR_W = 11;

   // OR with literal 0 leaves the accumulator untouched, so it doubles as NOP
   localparam logic [INSTR_W-1:0] NOP_INSTR = 11'h300;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_LDI = 3'd4;
   localparam logic [2:0] OP_SHL = 3'd5;
   localparam logic [2:0] OP_SHR = 3'd6;
   localparam logic [2:0] OP_XOR = 3'd7;

   localparam int FLAG_Z = 3;
   localparam int FLAG_C = 2;
   localparam int FLAG_N = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/feeder_prog_mem.sv
// Program store for the instruction feeder: DEPTH x 11 register file,
// written on the clock edge and read combinationally.
module feeder_prog_mem
   import feeder_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic                clk,
   input  logic                we,
   input  logic [ADDR_W-1:0]   waddr,
   input  logic [INSTR_W-1:0]  wdata,
   input  logic [ADDR_W-1:0]   raddr,
   output logic [INSTR_W-1:0]  rdata
);

   // No reset: the loaded program survives a feeder reset
   logic [INSTR_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/instruction_feeder.sv
// Feeds a stored program to the accumulator core one word per fetch strobe and
// captures the core's accumulator and flags after every executed instruction.
//
// state | meaning
// IDLE  | no program running, instr = NOP, loads accepted
// ARMED | start seen, waiting for a fetch edge to issue word 0
// RUN   | issuing one word per fetch edge, capturing the previous result
// DONE  | program finished, instr = NOP, loads accepted, results held
module instruction_feeder
   import feeder_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4,
   parameter int LOOP   = 0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                load_en,
   input  logic [ADDR_W-1:0]   load_addr,
   input  logic [10:0]         load_data,
   output logic                load_err,
   input  logic [ADDR_W:0]     prog_len,
   input  logic                start,
   input  logic                stop,
   input  logic                f,
   output logic [10:0]         instr,
   input  logic [7:0]          acc_in,
   input  logic [3:0]          flags_in,
   output logic [7:0]          last_acc,
   output logic [3:0]          last_flags,
   output logic                result_valid,
   output logic [7:0]          exec_count,
   output logic                busy,
   output logic                done
);

   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam logic            LOOP_EN = (LOOP != 0);

   feeder_state_e     state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W:0]   issued_q, issued_d;
   logic [ADDR_W:0]   eff_len_q, eff_len_d;
   logic [10:0]       instr_q, instr_d;
   logic [7:0]        last_acc_q, last_acc_d;
   logic [3:0]        last_flags_q, last_flags_d;
   logic              result_valid_q, result_valid_d;
   logic [7:0]        exec_count_q, exec_count_d;
   logic              load_err_q, load_err_d;
   logic              f_q;

   logic              fe;
   logic              go;
   logic              load_ok;
   logic              last_word;
   logic [ADDR_W:0]   len_clamped;
   logic [ADDR_W-1:0] mem_raddr;
   logic [10:0]       mem_rdata;

   assign fe          = f & ~f_q;
   assign go          = start & (prog_len != '0);
   assign load_ok     = (state_q == IDLE) || (state_q == DONE);
   assign last_word   = (issued_q >= eff_len_q);
   assign len_clamped = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
   // Looping back needs word 0 while pc still points past the last word
   assign mem_raddr   = last_word ? '0 : pc_q;

   feeder_prog_mem #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_prog_mem (
      .clk   (clk),
      .we    (load_en & load_ok),
      .waddr (load_addr),
      .wdata (load_data),
      .raddr (mem_raddr),
      .rdata (mem_rdata)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         pc_q           <= '0;
         issued_q       <= '0;
         eff_len_q      <= '0;
         instr_q        <= NOP_INSTR;
         last_acc_q     <= '0;
         last_flags_q   <= '0;
         result_valid_q <= 1'b0;
         exec_count_q   <= '0;
         load_err_q     <= 1'b0;
         f_q            <= 1'b0;
      end else begin
         state_q        <= state_d;
         pc_q           <= pc_d;
         issued_q       <= issued_d;
         eff_len_q      <= eff_len_d;
         instr_q        <= instr_d;
         last_acc_q     <= last_acc_d;
         last_flags_q   <= last_flags_d;
         result_valid_q <= result_valid_d;
         exec_count_q   <= exec_count_d;
         load_err_q     <= load_err_d;
         f_q            <= f;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (go) state_d = ARMED;
         ARMED: begin
            if (stop)    state_d = IDLE;
            else if (fe) state_d = RUN;
         end
         RUN: begin
            if (stop)                               state_d = IDLE;
            else if (fe && last_word && !LOOP_EN)   state_d = DONE;
         end
         DONE:    if (go) state_d = ARMED;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      pc_d           = pc_q;
      issued_d       = issued_q;
      eff_len_d      = eff_len_q;
      instr_d        = instr_q;
      last_acc_d     = last_acc_q;
      last_flags_d   = last_flags_q;
      exec_count_d   = exec_count_q;
      result_valid_d = 1'b0;
      load_err_d     = load_en & ~load_ok;
      case (state_q)
         IDLE, DONE: begin
            instr_d = NOP_INSTR;
            if (go) begin
               eff_len_d = len_clamped;
               pc_d      = '0;
               issued_d  = '0;
               if (state_q == DONE) exec_count_d = '0;
            end
         end
         ARMED: begin
            if (stop) begin
               instr_d  = NOP_INSTR;
               pc_d     = '0;
               issued_d = '0;
            end else if (fe) begin
               instr_d  = mem_rdata;
               pc_d     = ADDR_W'(1);
               issued_d = (ADDR_W+1)'(1);
            end
         end
         RUN: begin
            if (stop) begin
               instr_d  = NOP_INSTR;
               pc_d     = '0;
               issued_d = '0;
            end else if (fe) begin
               // The result on acc_in belongs to the instruction issued last time
               last_acc_d     = acc_in;
               last_flags_d   = flags_in;
               result_valid_d = 1'b1;
               if (exec_count_q != 8'hFF) exec_count_d = exec_count_q + 8'd1;
               if (!last_word) begin
                  instr_d  = mem_rdata;
                  pc_d     = pc_q + 1'b1;
                  issued_d = issued_q + 1'b1;
               end else if (LOOP_EN) begin
                  instr_d  = mem_rdata;
                  pc_d     = ADDR_W'(1);
                  issued_d = (ADDR_W+1)'(1);
               end else begin
                  instr_d = NOP_INSTR;
               end
            end
         end
         default: instr_d = NOP_INSTR;
      endcase
   end

   always_comb begin
      busy = (state_q == ARMED) || (state_q == RUN);
      done = (state_q == DONE);
   end

   assign instr        = instr_q;
   assign last_acc     = last_acc_q;
   assign last_flags   = last_flags_q;
   assign result_valid = result_valid_q;
   assign exec_count   = exec_count_q;
   assign load_err     = load_err_q;

endmodule

// File: tb/tb_instruction_feeder.sv
// Directed bench for instruction_feeder: a one-pass instance driven by a small
// accumulator-core model, plus a looping instance sharing the load and fetch inputs.
module tb_instruction_feeder;
   import feeder_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        load_en;
   logic [3:0]  load_addr;
   logic [10:0] load_data;
   logic [4:0]  prog_len;
   logic        start, stop, start_l, stop_l;
   logic        f;
   logic [7:0]  acc_in;
   logic [3:0]  flags_in;

   logic        load_err, result_valid, busy, done;
   logic [10:0] instr;
   logic [7:0]  last_acc, exec_count;
   logic [3:0]  last_flags;

   logic        load_err_l, result_valid_l, busy_l, done_l;
   logic [10:0] instr_l;
   logic [7:0]  last_acc_l, exec_count_l;
   logic [3:0]  last_flags_l;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   instruction_feeder #(.DEPTH(16), .ADDR_W(4), .LOOP(0)) dut (
      .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
      .load_data(load_data), .load_err(load_err), .prog_len(prog_len),
      .start(start), .stop(stop), .f(f), .instr(instr), .acc_in(acc_in),
      .flags_in(flags_in), .last_acc(last_acc), .last_flags(last_flags),
      .result_valid(result_valid), .exec_count(exec_count), .busy(busy), .done(done)
   );

   instruction_feeder #(.DEPTH(16), .ADDR_W(4), .LOOP(1)) dut_l (
      .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
      .load_data(load_data), .load_err(load_err_l), .prog_len(prog_len),
      .start(start_l), .stop(stop_l), .f(f), .instr(instr_l), .acc_in(acc_in),
      .flags_in(flags_in), .last_acc(last_acc_l), .last_flags(last_flags_l),
      .result_valid(result_valid_l), .exec_count(exec_count_l), .busy(busy_l), .done(done_l)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Executes ins on the modelled core and drives its result onto acc_in/flags_in
   task automatic core_exec(input logic [10:0] ins);
      logic [8:0] r;
      case (ins[10:8])
         OP_ADD:  r = {1'b0, acc_in} + {1'b0, ins[7:0]};
         OP_SUB:  r = {1'b0, acc_in} - {1'b0, ins[7:0]};
         OP_AND:  r = {1'b0, acc_in & ins[7:0]};
         OP_OR:   r = {1'b0, acc_in | ins[7:0]};
         OP_LDI:  r = {1'b0, ins[7:0]};
         OP_SHL:  r = {acc_in, 1'b0};
         OP_SHR:  r = {2'b00, acc_in[7:1]};
         default: r = {1'b0, acc_in ^ ins[7:0]};
      endcase
      acc_in   = r[7:0];
      flags_in = {(r[7:0] == 8'd0), r[8], r[7], 1'b0};
   endtask

   task automatic load_word(input logic [3:0] a, input logic [10:0] d);
      load_en = 1'b1; load_addr = a; load_data = d;
      tick();
      load_en = 1'b0;
   endtask

   task automatic do_start(input logic [4:0] len);
      prog_len = len; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Two quiet cycles then a one-cycle strobe: checks follow right after the edge
   task automatic fetch();
      tick(); tick();
      f = 1'b1;
      tick();
      f = 1'b0;
      core_exec(instr);
   endtask

   logic [10:0] loop_seq [6];

   initial begin
      loop_seq = '{11'h401, 11'h001, 11'h401, 11'h001, 11'h401, 11'h001};
      reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0; prog_len = '0;
      start = 1'b0; stop = 1'b0; start_l = 1'b0; stop_l = 1'b0; f = 1'b0;
      acc_in = '0; flags_in = '0;
      tick(); tick();
      reset = 1'b0;

      chk("rst_instr", instr, 11'h300);
      chk("rst_last_acc", last_acc, 0);
      chk("rst_exec_count", exec_count, 0);
      chk("rst_busy_done", {busy, done, result_valid, load_err}, 0);

      // Three-word program: LDI 5, ADD 3, SHL
      load_word(4'd0, 11'h405);
      load_word(4'd1, 11'h003);
      load_word(4'd2, 11'h500);
      do_start(5'd3);
      chk("t1_armed_busy", busy, 1);
      fetch();
      chk("t1_first_instr", instr, 11'h405);
      chk("t1_no_capture_armed", result_valid, 0);
      fetch();
      chk("t1_cap1", last_acc, 8'd5);
      chk("t1_cap1_valid", result_valid, 1);
      chk("t1_instr2", instr, 11'h003);
      tick();
      chk("t1_valid_pulse", result_valid, 0);
      fetch();
      chk("t1_cap2", last_acc, 8'd8);
      chk("t1_instr3", instr, 11'h500);
      fetch();
      chk("t1_cap3", last_acc, 8'd16);
      chk("t1_done", {busy, done}, 2'b01);
      chk("t1_exec_count", exec_count, 3);
      chk("t1_nop", instr, 11'h300);

      // LDI 0 then SUB 0: second capture is zero with the zero flag set
      load_word(4'd0, 11'h400);
      load_word(4'd1, 11'h100);
      do_start(5'd2);
      chk("t2_count_cleared", exec_count, 0);
      fetch();
      fetch();
      fetch();
      chk("t2_acc_zero", last_acc, 0);
      chk("t2_zero_flag", last_flags[FLAG_Z], 1);
      chk("t2_done", done, 1);

      // Load attempt while running is rejected
      do_start(5'd2);
      fetch();
      load_word(4'd1, 11'h7FF);
      chk("t4_load_err", load_err, 1);
      tick();
      chk("t4_load_err_pulse", load_err, 0);
      fetch();
      chk("t4_word1_kept_run", instr, 11'h100);
      fetch();
      chk("t4_done", done, 1);
      do_start(5'd2);
      fetch();
      fetch();
      chk("t4_readback", instr, 11'h100);
      stop = 1'b1; tick(); stop = 1'b0;
      chk("t4_stop_idle", {busy, done}, 0);
      chk("t4_stop_nop", instr, 11'h300);

      // f held high for four cycles in ARMED gives one issue only
      load_word(4'd0, 11'h401);
      load_word(4'd1, 11'h402);
      load_word(4'd2, 11'h403);
      load_word(4'd3, 11'h404);
      do_start(5'd4);
      tick(); tick();
      f = 1'b1;
      repeat (4) tick();
      f = 1'b0;
      core_exec(instr);
      chk("t5_held_instr", instr, 11'h401);
      chk("t5_held_no_capture", exec_count, 1);
      fetch();
      chk("t5_next_is_word1", instr, 11'h402);
      chk("t5_capture", exec_count, 2);
      chk("t5_acc", last_acc, 1);

      // stop together with a fetch edge wins, no capture
      tick(); tick();
      f = 1'b1; stop = 1'b1;
      tick();
      f = 1'b0; stop = 1'b0;
      chk("t6_stop_idle", {busy, done}, 0);
      chk("t6_stop_nop", instr, 11'h300);
      chk("t6_stop_no_valid", result_valid, 0);
      chk("t6_stop_kept_acc", last_acc, 1);
      chk("t6_stop_kept_count", exec_count, 2);

      // Asynchronous reset in the middle of a run
      do_start(5'd4);
      fetch();
      fetch();
      chk("t6_rerun_instr", instr, 11'h402);
      #2 reset = 1'b1;
      #1;
      chk("t6_rst_instr", instr, 11'h300);
      chk("t6_rst_last_acc", last_acc, 0);
      chk("t6_rst_count_busy", {exec_count, busy}, 0);
      tick();
      reset = 1'b0;
      fetch();
      chk("t6_after_rst_idle", {busy, result_valid, instr}, {2'b00, 11'h300});

      // prog_len of zero is ignored
      do_start(5'd0);
      chk("t7_len0_ignored", busy, 0);

      // Looping instance: two-word program repeated
      load_word(4'd0, 11'h401);
      load_word(4'd1, 11'h001);
      acc_in = 8'h5A; flags_in = 4'b0010;
      prog_len = 5'd2; start_l = 1'b1;
      tick();
      start_l = 1'b0;
      for (int i = 0; i < 6; i++) begin
         fetch();
         chk($sformatf("t3_loop_instr%0d", i), instr_l, loop_seq[i]);
         chk($sformatf("t3_loop_busy%0d", i), {busy_l, done_l}, 2'b10);
      end
      chk("t3_loop_count", exec_count_l, 5);
      chk("t3_loop_valid", result_valid_l, 1);
      chk("t3_loop_acc", {last_acc_l, last_flags_l}, {8'h5A, 4'b0000});
      chk("t3_loop_no_err", load_err_l, 0);
      stop_l = 1'b1; tick(); stop_l = 1'b0;
      chk("t3_loop_stop", {busy_l, instr_l}, {1'b0, 11'h300});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
